// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks.
// Holds the operand widths, the state encoding of the modular
// exponentiation sequencer, and the states of the go/done handshake.
package rsa_pkg;

  // Width of base, exponent, modulus and result.
  localparam int HALFBITS = 4;
  // Width of the reduction operands; holds any product of two HALFBITS values.
  localparam int BITS     = 2 * HALFBITS + 1;

  // Algorithm sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    RED_BASE,
    SQUARE,
    MULT,
    FINISH
  } top_state_e;

  // Reduction handshake states. HS_IDLE is the parked state between runs.
  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_WAIT,
    HS_REL
  } hs_state_e;

endpackage

// File: rtl/mod_req.sv
// Initiator side of the go/done modulo-reduction handshake.
// The parent raises req with a stable operand; this block registers the
// operand onto mod_y together with mod_go, waits for mod_done, captures the
// truncated remainder, then holds mod_go low for two cycles. ack pulses in the
// first release cycle so the parent can present its next request in time to
// be launched right at the end of the release window.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req, operand      request from parent and the dividend to reduce
//   ack, rem          one-cycle completion strobe and captured remainder
//   mod_go, mod_y     request level and dividend to the responder
//   mod_r, mod_done   remainder and valid from the responder
module mod_req #(
  parameter int HALFBITS = rsa_pkg::HALFBITS,
  parameter int BITS     = rsa_pkg::BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [BITS-1:0]     operand,
  output logic                ack,
  output logic [HALFBITS-1:0] rem,
  output logic                mod_go,
  output logic [BITS-1:0]     mod_y,
  input  logic [BITS-1:0]     mod_r,
  input  logic                mod_done
);
  import rsa_pkg::*;

  hs_state_e           hs_q, hs_d;
  logic                go_q, go_d;
  logic [BITS-1:0]     y_q, y_d;
  logic [HALFBITS-1:0] rem_q, rem_d;
  logic                armed_q, armed_d;
  logic                rel_last_q, rel_last_d;
  logic                unused_rem_hi;

  assign unused_rem_hi = ^mod_r[BITS-1:HALFBITS];

  // go is a flop so reset pulls it low asynchronously, releasing the responder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q       <= HS_IDLE;
      go_q       <= 1'b0;
      y_q        <= '0;
      rem_q      <= '0;
      armed_q    <= 1'b0;
      rel_last_q <= 1'b0;
    end else begin
      hs_q       <= hs_d;
      go_q       <= go_d;
      y_q        <= y_d;
      rem_q      <= rem_d;
      armed_q    <= armed_d;
      rel_last_q <= rel_last_d;
    end
  end

  // armed_q masks mod_done on the first WAIT edge so a done left over from
  // the previous transaction is never mistaken for the new one.
  always_comb begin
    hs_d       = hs_q;
    go_d       = go_q;
    y_d        = y_q;
    rem_d      = rem_q;
    armed_d    = armed_q;
    rel_last_d = rel_last_q;
    case (hs_q)
      HS_IDLE: begin
        if (req) hs_d = HS_REQ;
      end
      HS_REQ: begin
        go_d    = 1'b1;
        y_d     = operand;
        armed_d = 1'b0;
        hs_d    = HS_WAIT;
      end
      HS_WAIT: begin
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (mod_done) begin
          rem_d      = mod_r[HALFBITS-1:0];
          go_d       = 1'b0;
          rel_last_d = 1'b0;
          hs_d       = HS_REL;
        end
      end
      HS_REL: begin
        if (!rel_last_q) begin
          rel_last_d = 1'b1;
        end else if (req) begin
          go_d    = 1'b1;
          y_d     = operand;
          armed_d = 1'b0;
          hs_d    = HS_WAIT;
        end else begin
          hs_d = HS_IDLE;
        end
      end
      default: hs_d = HS_IDLE;
    endcase
  end

  always_comb begin
    ack    = (hs_q == HS_REL) && !rel_last_q;
    mod_go = go_q;
    mod_y  = y_q;
    rem    = rem_q;
  end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation controller.
// Sequences base reduction, then per exponent bit a square and an optional
// multiply, each delegated to an external reducer through mod_req.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, base, exp, modulus  one-cycle request and its operands
//   result, busy, done, err    answer (valid with done), status, n=0 flag
//   mod_go, mod_x, mod_y       request, divisor, dividend to the reducer
//   mod_r, mod_done            remainder and valid from the reducer
module modexp_ctrl #(
  parameter int HALFBITS = rsa_pkg::HALFBITS,
  parameter int BITS     = rsa_pkg::BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [HALFBITS-1:0] base,
  input  logic [HALFBITS-1:0] exp,
  input  logic [HALFBITS-1:0] modulus,
  output logic [HALFBITS-1:0] result,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                mod_go,
  output logic [BITS-1:0]     mod_x,
  output logic [BITS-1:0]     mod_y,
  input  logic [BITS-1:0]     mod_r,
  input  logic                mod_done
);
  import rsa_pkg::*;

  localparam int IW = (HALFBITS > 1) ? $clog2(HALFBITS) : 1;

  top_state_e          state_q, state_d;
  logic [HALFBITS-1:0] base_q, base_d;
  logic [HALFBITS-1:0] exp_q, exp_d;
  logic [HALFBITS-1:0] mod_q, mod_d;
  logic [HALFBITS-1:0] b_q, b_d;
  logic [HALFBITS-1:0] acc_q, acc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                err_q, err_d;
  logic [HALFBITS-1:0] result_q, result_d;

  logic                req, ack;
  logic [BITS-1:0]     operand;
  logic [HALFBITS-1:0] rem;
  logic [BITS-1:0]     acc_w, b_w;

  mod_req #(.HALFBITS(HALFBITS), .BITS(BITS)) u_mod_req (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .operand  (operand),
    .ack      (ack),
    .rem      (rem),
    .mod_go   (mod_go),
    .mod_y    (mod_y),
    .mod_r    (mod_r),
    .mod_done (mod_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Every bit is processed, leading zeros included, so exp=0 yields 1 mod n
  // and n=1 collapses to 0 without any special casing.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    b_d      = b_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base;
          exp_d  = exp;
          mod_d  = modulus;
          acc_d  = HALFBITS'(1);
          idx_d  = IW'(HALFBITS - 1);
          if (modulus == '0) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = FINISH;
          end else begin
            err_d   = 1'b0;
            state_d = RED_BASE;
          end
        end
      end
      RED_BASE: begin
        if (ack) begin
          b_d     = rem;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        if (ack) begin
          acc_d = rem;
          if (exp_q[idx_q]) begin
            state_d = MULT;
          end else if (idx_q == '0) begin
            result_d = rem;
            state_d  = FINISH;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      MULT: begin
        if (ack) begin
          acc_d = rem;
          if (idx_q == '0) begin
            result_d = rem;
            state_d  = FINISH;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = SQUARE;
          end
        end
      end
      FINISH: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // busy stays high through the done cycle, so a start coinciding with done
  // is never accepted.
  always_comb begin
    acc_w   = BITS'(acc_q);
    b_w     = BITS'(b_q);
    req     = (state_q == RED_BASE) || (state_q == SQUARE) || (state_q == MULT);
    operand = '0;
    case (state_q)
      RED_BASE: operand = BITS'(base_q);
      SQUARE:   operand = acc_w * acc_w;
      MULT:     operand = acc_w * b_w;
      default:  operand = '0;
    endcase
    busy   = (state_q != IDLE);
    done   = (state_q == FINISH);
    err    = (state_q == FINISH) && err_q;
    result = result_q;
    mod_x  = BITS'(mod_q);
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl with a behavioural reduction responder
// of random latency and a plain-arithmetic exponentiation reference model.
module tb_modexp_ctrl;
  import rsa_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [HALFBITS-1:0] base, exp, modulus;
  logic [HALFBITS-1:0] result;
  logic                busy, done, err;
  logic                mod_go;
  logic [BITS-1:0]     mod_x, mod_y, mod_r;
  logic                mod_done;

  int checks = 0;
  int errors = 0;

  int              req_count = 0;
  logic [BITS-1:0] run_n = '0;
  logic [BITS-1:0] cap_y;
  bit              active = 0;
  int              lat, wait_cnt;
  bit              go_prev = 0;
  bit              had_fall = 0;
  int              low_cnt = 0;

  modexp_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .exp      (exp),
    .modulus  (modulus),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mod_go   (mod_go),
    .mod_x    (mod_x),
    .mod_y    (mod_y),
    .mod_r    (mod_r),
    .mod_done (mod_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: repeated multiplication, independent of the bit-serial method.
  function automatic int refModexp(int b, int e, int n);
    int r;
    if (n == 0) return 0;
    r = 1 % n;
    for (int k = 0; k < e; k++) r = (r * b) % n;
    return r;
  endfunction

  function automatic int refReqs(int e, int n);
    if (n == 0) return 0;
    return 1 + HALFBITS + $countones(e[HALFBITS-1:0]);
  endfunction

  // Responder plus handshake observers, all sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mod_done = 1'b0;
      mod_r    = '0;
      active   = 0;
      go_prev  = 0;
      had_fall = 0;
      low_cnt  = 0;
    end else begin
      if (mod_go && !go_prev && had_fall) checkOutput("release_gap", low_cnt, 2);
      if (!mod_go && go_prev) begin
        had_fall = 1;
        low_cnt  = 0;
      end
      if (!mod_go) low_cnt++;
      go_prev = mod_go;

      if (!mod_go) begin
        mod_done = 1'b0;
        active   = 0;
        mod_r    = BITS'($urandom);
      end else if (!active) begin
        active   = 1;
        lat      = $urandom_range(3, 20);
        wait_cnt = 0;
        cap_y    = mod_y;
        req_count++;
        checkOutput("mod_x_value", mod_x, run_n);
      end else begin
        if (mod_y !== cap_y) checkOutput("mod_y_stable", mod_y, cap_y);
        if (!mod_done) begin
          wait_cnt++;
          if (wait_cnt >= lat) begin
            mod_r    = (mod_x == '0) ? '0 : (mod_y % mod_x);
            mod_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_result"}, result, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_mod_go"}, mod_go, 0);
    checkOutput({tag, "_mod_x"}, mod_x, 0);
    checkOutput({tag, "_mod_y"}, mod_y, 0);
  endtask

  // Pulses start and checks the fixed two-cycle launch latency.
  task automatic startRun(input int b, input int e, input int n);
    start     = 1'b1;
    base      = HALFBITS'(b);
    exp       = HALFBITS'(e);
    modulus   = HALFBITS'(n);
    run_n     = BITS'(n);
    req_count = 0;
    had_fall  = 0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    if (n != 0) begin
      checkOutput("go_low_cycle0", mod_go, 0);
      @(negedge clk);
      checkOutput("go_low_cycle1", mod_go, 0);
      @(negedge clk);
      checkOutput("go_high_cycle2", mod_go, 1);
    end
  endtask

  task automatic waitDone(input string name, input int exp_res, input int exp_err,
                          input int exp_reqs);
    int cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: done never seen, expected within 5000 cycles", name);
    end else begin
      checkOutput({name, "_result"}, result, exp_res);
      checkOutput({name, "_err"}, err, exp_err);
      checkOutput({name, "_busy_at_done"}, busy, 1);
      checkOutput({name, "_requests"}, req_count, exp_reqs);
      @(negedge clk);
      checkOutput({name, "_done_pulse"}, done, 0);
      checkOutput({name, "_busy_clear"}, busy, 0);
      checkOutput({name, "_err_pulse"}, err, 0);
    end
  endtask

  task automatic applyStimulus(input string name, input int b, input int e, input int n,
                               input int exp_res, input int exp_err, input int exp_reqs);
    startRun(b, e, n);
    waitDone(name, exp_res, exp_err, exp_reqs);
    @(negedge clk);
  endtask

  typedef struct {
    string name;
    int    b, e, n;
    int    res, err, reqs;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int b, e, n, cyc;

    vecs[0] = '{"v4_13_15", 4, 13, 15, 4, 0, 8};
    vecs[1] = '{"v13_15_7", 13, 15, 7, 6, 0, 9};
    vecs[2] = '{"v7_0_11", 7, 0, 11, 1, 0, 5};
    vecs[3] = '{"v9_5_1", 9, 5, 1, 0, 0, 7};
    vecs[4] = '{"v10_6_0", 10, 6, 0, 0, 1, 0};

    rst_n    = 1'b0;
    start    = 1'b0;
    base     = '0;
    exp      = '0;
    modulus  = '0;
    mod_done = 1'b0;
    mod_r    = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] directed vectors");
    foreach (vecs[k])
      applyStimulus(vecs[k].name, vecs[k].b, vecs[k].e, vecs[k].n,
                    vecs[k].res, vecs[k].err, vecs[k].reqs);

    $display("[TB] randomized runs against reference model");
    for (int k = 0; k < 16; k++) begin
      b = $urandom_range(0, 15);
      e = $urandom_range(0, 15);
      n = $urandom_range(0, 15);
      applyStimulus($sformatf("rand%0d", k), b, e, n,
                    refModexp(b, e, n), (n == 0) ? 1 : 0, refReqs(e, n));
    end

    $display("[TB] start while busy is ignored");
    startRun(4, 13, 15);
    repeat (10) @(negedge clk);
    start   = 1'b1;
    base    = 4'd3;
    exp     = 4'd5;
    modulus = 4'd7;
    @(negedge clk);
    start = 1'b0;
    waitDone("midstart", 4, 0, 8);
    @(negedge clk);

    $display("[TB] reset during WAIT");
    startRun(4, 13, 15);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset_go", mod_go, 1);
    rst_n = 1'b0;
    #1;
    checkResetState("midwait_reset");
    @(negedge clk);
    checkResetState("held_reset");
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("after_reset", 4, 13, 15, 4, 0, 8);

    cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
